// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating an instruction-fetch
// port and a load/store port onto a single 8-bit synchronous RAM.
// Loads and stores move one byte per cycle, little-endian, low address first.
module mem_ctrl #(
   parameter int RAM_AW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [1:0]        mem_len,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [RAM_AW-1:0] ram_a,
   output logic              ram_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;     // edges spent in READ/WRITE since acceptance
   logic [2:0]  r_len;     // transfer length in bytes (1, 2 or 4)
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic [31:0] r_buf;     // captured bytes, newest byte shifted in at the top
   logic        r_is_if;

   logic [2:0]  w_k;
   logic [31:0] w_next_addr;
   logic [31:0] w_wsel;
   logic [31:0] w_rd_final;
   logic [2:0]  w_mem_n;

   // byte index handled at this edge and its wrapped 32-bit address
   assign w_k         = r_cnt + 3'd1;
   assign w_next_addr = r_addr + {29'd0, w_k};
   assign w_wsel      = r_wd >> {w_k, 3'b000};
   assign w_mem_n     = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;

   // final load word: last byte arrives on ram_din, earlier ones sit in r_buf's top bytes
   always_comb begin
      w_rd_final = 32'd0;
      case (r_len)
         3'd1:    w_rd_final = {24'd0, ram_din};
         3'd2:    w_rd_final = {16'd0, ram_din, r_buf[31:24]};
         default: w_rd_final = {ram_din, r_buf[31:8]};
      endcase
   end

   // controller FSM with all outputs registered; rdy=0 freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 3'd0;
         r_len     <= 3'd0;
         r_addr    <= 32'd0;
         r_wd      <= 32'd0;
         r_buf     <= 32'd0;
         r_is_if   <= 1'b0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         if_inst   <= 32'd0;
         mem_rdata <= 32'd0;
         ram_dout  <= 8'd0;
         ram_a     <= '0;
         ram_wr    <= 1'b0;
      end else if (rdy) begin
         case (r_state)
            IDLE: begin
               r_cnt <= 3'd0;
               r_buf <= 32'd0;
               // load/store port wins over instruction fetch
               if (mem_req) begin
                  r_is_if <= 1'b0;
                  r_addr  <= mem_addr;
                  r_len   <= w_mem_n;
                  r_wd    <= mem_wdata;
                  ram_a   <= mem_addr[RAM_AW-1:0];
                  if (mem_we) begin
                     ram_wr   <= 1'b1;
                     ram_dout <= mem_wdata[7:0];
                     r_state  <= WRITE;
                  end else begin
                     r_state  <= READ;
                  end
               end else if (if_req) begin
                  r_is_if <= 1'b1;
                  r_addr  <= if_addr;
                  r_len   <= 3'd4;
                  r_wd    <= 32'd0;
                  ram_a   <= if_addr[RAM_AW-1:0];
                  r_state <= READ;
               end
            end
            READ: begin
               r_cnt <= w_k;
               if (w_k < r_len)
                  ram_a <= w_next_addr[RAM_AW-1:0];
               if (r_cnt != 3'd0)
                  r_buf <= {ram_din, r_buf[31:8]};
               if (r_cnt == r_len) begin
                  if (r_is_if) begin
                     if_done <= 1'b1;
                     if_inst <= w_rd_final;
                  end else begin
                     mem_done  <= 1'b1;
                     mem_rdata <= w_rd_final;
                  end
                  r_state <= DONE;
               end
            end
            WRITE: begin
               r_cnt <= w_k;
               if (w_k < r_len) begin
                  ram_a    <= w_next_addr[RAM_AW-1:0];
                  ram_dout <= w_wsel[7:0];
                  ram_wr   <= 1'b1;
               end else begin
                  ram_wr   <= 1'b0;
                  mem_done <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               // DONE lasts one cycle and never accepts a request
               if_done  <= 1'b0;
               mem_done <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 32, width of ram_a; the byte address is truncated to its low RAM_AW bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  chip ready; 0 = freeze (RAM is frozen by the same rdy).
REQ-005 SHALL have port if_req  input  1  instruction fetch request; held until if_done.
REQ-006 SHALL have port if_addr  input  32  fetch byte address.
REQ-007 SHALL have port if_done  output  1  one-cycle pulse; if_inst is valid in the same cycle.
REQ-008 SHALL have port if_inst  output  32  fetched word, little-endian.
REQ-009 SHALL have port mem_req  input  1  load/store request; held until mem_done.
REQ-010 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port mem_addr  input  32  load/store byte address.
REQ-012 SHALL have port mem_len  input  2  size code: 00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
REQ-013 SHALL have port mem_wdata  input  32  store data; low bytes are used first.
REQ-014 SHALL have port mem_done  output  1  one-cycle pulse on load or store completion.
REQ-015 SHALL have port mem_rdata  output  32  load data, zero-extended.
REQ-016 SHALL have port ram_din  input  8  RAM read byte; valid the cycle after the RAM samples its address.
REQ-017 SHALL have port ram_dout  output  8  RAM write byte.
REQ-018 SHALL have port ram_a  output  RAM_AW  RAM byte address.
REQ-019 SHALL have port ram_wr  output  1  1 = write, 0 = read.

Function
REQ-020 SHALL implement the FSM states IDLE, READ, WRITE and DONE; all outputs SHALL be registered.
REQ-021 IDLE arbitration: at an edge with mem_req=1, SHALL accept the MEM request; else at an edge with if_req=1, SHALL accept the IF request; else SHALL remain in IDLE.
REQ-022 On acceptance SHALL latch the address, write flag, length N (IF always 4) and write data, and SHALL reset byte counter i to 0.
REQ-023 Request inputs SHALL be ignored outside IDLE.
REQ-024 Write: during the cycle after acceptance edge E0+i (i = 0..N-1), SHALL drive ram_a = addr+i, ram_dout = byte i and ram_wr = 1.
REQ-025 Write: the done pulse SHALL occur in the cycle after E(N).
REQ-026 Read: during the cycle after E(i), i < N, SHALL drive ram_a = addr+i with ram_wr = 0.
REQ-027 Read: SHALL capture ram_din as byte i at edge E(i+2); done and data SHALL be valid in the cycle after E(N+1).
REQ-028 The DONE state SHALL last exactly one cycle and assert exactly one done (if_done or mem_done); requests SHALL NOT be accepted at the edge ending DONE.
REQ-029 Requesters SHALL deassert their request by that edge; FSM then SHALL return to IDLE.
REQ-030 Address increment SHALL wrap modulo 2^32 before truncation to RAM_AW.
REQ-031 mem_rdata bytes beyond N SHALL be 0; if_inst and mem_rdata SHALL hold their value until the next completion of the same port.
REQ-032 ram_wr SHALL be 0 in IDLE, READ and DONE; ram_a SHALL hold its last value when idle.
REQ-033 rdy=0: all registers (state, counter, buffers, outputs) SHALL hold; done pulses SHALL stretch across the freeze; operation SHALL resume unchanged when rdy=1.
REQ-034 rst=1 SHALL take priority over rdy.

Reset
REQ-035 At an edge with rst=1: state SHALL = IDLE, i = 0, if_done = mem_done = 0, ram_wr = 0, ram_a = 0, ram_dout = 0, if_inst = mem_rdata = 0; any in-flight access SHALL be aborted without done.
REQ-036 The first acceptance after reset SHALL be possible at the first edge with rst=0.

Verification
REQ-037 Fetch: RAM[0x100..0x103] = 13,05,00,00, if_req at E0 -> four reads 0x100..0x103, if_done in the cycle after E5, if_inst = 0x00000513.
REQ-038 Halfword store: mem_addr = 0x20, mem_wdata = 0x1234BEEF, mem_len = 01 -> writes 0xEF@0x20, 0xBE@0x21, mem_done in the cycle after E2; no other writes.
REQ-039 Conflict: if_req and mem_req (byte load, RAM[0x40] = 0x80) both high at E0 -> mem_rdata = 0x00000080 first; the IF access starts only after DONE; single done per access.
REQ-040 Wrap: word load at 0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (truncated to RAM_AW).
REQ-041 rdy=0 for 3 cycles mid word-read -> identical data, with done delayed by exactly 3 cycles.
REQ-042 rst at E2 of a word store -> ram_wr = 0 from the next cycle, no mem_done; a new request is accepted at the first rst=0 edge.
